// File: rtl/ysyx_25040109_wbu.sv
// Writeback unit: retires one instruction per handshake, drives the GPR and CSR write
// ports, and sequences the two-cycle ecall trap (mepc, then mcause plus redirect).
module ysyx_25040109_wbu #(
    parameter int unsigned               DATA_WIDTH   = 32,
    parameter int unsigned               ADDR_WIDTH   = 5,
    parameter logic [DATA_WIDTH-1:0]     MCAUSE_ECALL = 'd11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic [DATA_WIDTH-1:0] in_rd_data,
    input  logic [1:0]            in_csr_op,
    input  logic [11:0]           in_csr_addr,
    input  logic [DATA_WIDTH-1:0] in_csr_wdata,
    input  logic [DATA_WIDTH-1:0] mtvec_in,
    input  logic [DATA_WIDTH-1:0] mepc_in,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  csr_we,
    output logic [11:0]           csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_pc,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // upstream holds its payload stable until then, and in_valid is ignored otherwise.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_CAUSE = 2'd2
    } state_e;

    localparam logic [1:0]  OP_NONE  = 2'd0;
    localparam logic [1:0]  OP_CSRW  = 2'd1;
    localparam logic [1:0]  OP_ECALL = 2'd2;
    localparam logic [1:0]  OP_MRET  = 2'd3;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   rd_q, rd_d;
    logic                    rd_wen_q, rd_wen_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [1:0]              csr_op_q, csr_op_d;
    logic [11:0]             csr_addr_q, csr_addr_d;
    logic [DATA_WIDTH-1:0]   csr_wdata_q, csr_wdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            rd_q        <= '0;
            rd_wen_q    <= 1'b0;
            rd_data_q   <= '0;
            csr_op_q    <= OP_NONE;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            rd_wen_q    <= rd_wen_d;
            rd_data_q   <= rd_data_d;
            csr_op_q    <= csr_op_d;
            csr_addr_q  <= csr_addr_d;
            csr_wdata_q <= csr_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rd_d        = rd_q;
        rd_wen_d    = rd_wen_q;
        rd_data_d   = rd_data_q;
        csr_op_d    = csr_op_q;
        csr_addr_d  = csr_addr_q;
        csr_wdata_d = csr_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pc_d        = in_pc;
                    rd_d        = in_rd;
                    rd_wen_d    = in_rd_wen;
                    rd_data_d   = in_rd_data;
                    csr_op_d    = in_csr_op;
                    csr_addr_d  = in_csr_addr;
                    csr_wdata_d = in_csr_wdata;
                    state_d     = S_WB;
                end
            end
            S_WB:    state_d = (csr_op_q == OP_ECALL) ? S_CAUSE : S_IDLE;
            S_CAUSE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend only on state and captured fields, never on the live in_* bus.
    always_comb begin
        in_ready       = (state_q == S_IDLE);
        rf_wen         = 1'b0;
        rf_waddr       = rd_q;
        rf_wdata       = rd_data_q;
        csr_we         = 1'b0;
        csr_addr       = csr_addr_q;
        csr_wdata      = csr_wdata_q;
        commit_valid   = 1'b0;
        commit_pc      = pc_q;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            S_WB: begin
                if (csr_op_q == OP_ECALL) begin
                    csr_we    = 1'b1;
                    csr_addr  = CSR_MEPC;
                    csr_wdata = pc_q;
                end else begin
                    rf_wen       = rd_wen_q && (rd_q != '0);
                    commit_valid = 1'b1;
                    csr_we       = (csr_op_q == OP_CSRW);
                    if (csr_op_q == OP_MRET) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = mepc_in;
                    end
                end
            end
            S_CAUSE: begin
                csr_we         = 1'b1;
                csr_addr       = CSR_MCAUSE;
                csr_wdata      = MCAUSE_ECALL;
                commit_valid   = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = mtvec_in;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040109_wbu.sv
// Directed bench for the writeback unit: reset, plain GPR writeback, x0 suppression,
// CSR write, ecall trap sequence, mret, back-to-back acceptance and reset mid-instruction.
module tb_ysyx_25040109_wbu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [31:0] in_rd_data;
  logic [1:0]  in_csr_op;
  logic [11:0] in_csr_addr;
  logic [31:0] in_csr_wdata;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  ysyx_25040109_wbu dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rd          (in_rd),
    .in_rd_wen      (in_rd_wen),
    .in_rd_data     (in_rd_data),
    .in_csr_op      (in_csr_op),
    .in_csr_addr    (in_csr_addr),
    .in_csr_wdata   (in_csr_wdata),
    .mtvec_in       (mtvec_in),
    .mepc_in        (mepc_in),
    .rf_wen         (rf_wen),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                       input logic [31:0] data, input logic [1:0] op,
                       input logic [11:0] caddr, input logic [31:0] cdata);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_rd        = rd;
    in_rd_wen    = wen;
    in_rd_data   = data;
    in_csr_op    = op;
    in_csr_addr  = caddr;
    in_csr_wdata = cdata;
  endtask

  task automatic idle_bus();
    in_valid     = 1'b0;
    in_pc        = '0;
    in_rd        = '0;
    in_rd_wen    = 1'b0;
    in_rd_data   = '0;
    in_csr_op    = '0;
    in_csr_addr  = '0;
    in_csr_wdata = '0;
  endtask

  task automatic test_reset();
    idle_bus();
    mtvec_in = 32'h0;
    mepc_in  = 32'h0;
    rst = 1'b1;
    #3;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
    n_checks++; if ({rf_wen, csr_we, commit_valid, redirect_valid} !== 4'b0000) begin n_fail++; $display("FAIL reset_enables got %b want 0000", {rf_wen, csr_we, commit_valid, redirect_valid}); end
    n_checks++; if ({rf_waddr, rf_wdata, csr_addr, csr_wdata} !== 81'h0) begin n_fail++; $display("FAIL reset_rf_csr_data got %h want 0", {rf_waddr, rf_wdata, csr_addr, csr_wdata}); end
    n_checks++; if ({commit_pc, redirect_pc} !== 64'h0) begin n_fail++; $display("FAIL reset_pc_outs got %h want 0", {commit_pc, redirect_pc}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_addi();
    drive(32'h8000_0000, 5'd5, 1'b1, 32'h1234, 2'd0, 12'h0, 32'h0);
    step();
    idle_bus();
    in_rd_data = 32'hDEAD_BEEF;  // live bus must not leak into writeback
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL addi_ready_wb got %0h want 0", in_ready); end
    n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL addi_rf_wen got %0h want 1", rf_wen); end
    n_checks++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL addi_rf_waddr got %0d want 5", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL addi_rf_wdata got %h want 00001234", rf_wdata); end
    n_checks++; if (commit_valid !== 1'b1 || commit_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL addi_commit got %0h/%h want 1/80000000", commit_valid, commit_pc); end
    n_checks++; if (csr_we !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL addi_no_csr_redirect got %0h/%0h want 0/0", csr_we, redirect_valid); end
    step();
    n_checks++; if (in_ready !== 1'b1 || rf_wen !== 1'b0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL addi_after got ready=%0h wen=%0h commit=%0h want 1/0/0", in_ready, rf_wen, commit_valid); end
    n_checks++; if (rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL addi_hold_wdata got %h want 00001234", rf_wdata); end
    idle_bus();
  endtask

  task automatic test_rd_zero();
    drive(32'h8000_0004, 5'd0, 1'b1, 32'h55, 2'd0, 12'h0, 32'h0);
    step();
    idle_bus();
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL rd0_rf_wen got %0h want 0", rf_wen); end
    n_checks++; if (commit_valid !== 1'b1 || commit_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL rd0_commit got %0h/%h want 1/80000004", commit_valid, commit_pc); end
    step();
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL rd0_single_pulse got %0h want 0", commit_valid); end
  endtask

  task automatic test_csrrw();
    drive(32'h8000_0008, 5'd3, 1'b1, 32'h0, 2'd1, 12'h305, 32'h8000_0100);
    step();
    idle_bus();
    n_checks++; if (csr_we !== 1'b1 || csr_addr !== 12'h305 || csr_wdata !== 32'h8000_0100) begin n_fail++; $display("FAIL csrrw_csr got %0h/%h/%h want 1/305/80000100", csr_we, csr_addr, csr_wdata); end
    n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h0) begin n_fail++; $display("FAIL csrrw_rf got %0h/%0d/%h want 1/3/0", rf_wen, rf_waddr, rf_wdata); end
    n_checks++; if (commit_valid !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL csrrw_commit got %0h/%0h want 1/0", commit_valid, redirect_valid); end
    step();
    n_checks++; if (csr_we !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL csrrw_after got %0h/%0h want 0/1", csr_we, in_ready); end
  endtask

  task automatic test_ecall();
    mtvec_in = 32'h8000_0100;
    drive(32'h8000_0010, 5'd1, 1'b1, 32'h77, 2'd2, 12'h0, 32'h0);
    step();
    idle_bus();
    n_checks++; if (csr_we !== 1'b1 || csr_addr !== 12'h341 || csr_wdata !== 32'h8000_0010) begin n_fail++; $display("FAIL ecall_mepc got %0h/%h/%h want 1/341/80000010", csr_we, csr_addr, csr_wdata); end
    n_checks++; if (rf_wen !== 1'b0 || commit_valid !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ecall_wb_quiet got %0h/%0h/%0h want 0/0/0", rf_wen, commit_valid, redirect_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ecall_ready_wb got %0h want 0", in_ready); end
    step();
    n_checks++; if (csr_we !== 1'b1 || csr_addr !== 12'h342 || csr_wdata !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause got %0h/%h/%h want 1/342/0000000b", csr_we, csr_addr, csr_wdata); end
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL ecall_redirect got %0h/%h want 1/80000100", redirect_valid, redirect_pc); end
    n_checks++; if (commit_valid !== 1'b1 || commit_pc !== 32'h8000_0010 || in_ready !== 1'b0 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL ecall_cause_commit got c=%0h pc=%h r=%0h w=%0h want 1/80000010/0/0", commit_valid, commit_pc, in_ready, rf_wen); end
    step();
    n_checks++; if (in_ready !== 1'b1 || commit_valid !== 1'b0 || csr_we !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ecall_after got r=%0h c=%0h we=%0h rv=%0h want 1/0/0/0", in_ready, commit_valid, csr_we, redirect_valid); end
  endtask

  task automatic test_mret();
    mepc_in = 32'h8000_0014;
    drive(32'h8000_0200, 5'd0, 1'b0, 32'h0, 2'd3, 12'h0, 32'h0);
    step();
    idle_bus();
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0014) begin n_fail++; $display("FAIL mret_redirect got %0h/%h want 1/80000014", redirect_valid, redirect_pc); end
    n_checks++; if (csr_we !== 1'b0 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL mret_no_writes got %0h/%0h want 0/0", csr_we, rf_wen); end
    n_checks++; if (commit_valid !== 1'b1 || commit_pc !== 32'h8000_0200) begin n_fail++; $display("FAIL mret_commit got %0h/%h want 1/80000200", commit_valid, commit_pc); end
    step();
    n_checks++; if (redirect_valid !== 1'b0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL mret_after got %0h/%0h want 0/0", redirect_valid, commit_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    for (int i = 0; i < 4; i++) begin
      drive(32'h8000_1000 + 32'(i * 4), 5'(i + 1), 1'b1, 32'h100 + 32'(i), 2'd0, 12'h0, 32'h0);
      exp_q.push_back(32'h100 + 32'(i));
      step();
      exp_data = exp_q.pop_front();
      n_checks++; if (in_ready !== 1'b0 || rf_wen !== 1'b1 || rf_wdata !== exp_data || rf_waddr !== 5'(i + 1)) begin n_fail++; $display("FAIL b2b_wb[%0d] got r=%0h w=%0h d=%h a=%0d want 0/1/%h/%0d", i, in_ready, rf_wen, rf_wdata, rf_waddr, exp_data, i + 1); end
      step();
      n_checks++; if (in_ready !== 1'b1 || rf_wen !== 1'b0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d] got r=%0h w=%0h c=%0h want 1/0/0", i, in_ready, rf_wen, commit_valid); end
    end
    idle_bus();
    step();
  endtask

  task automatic test_reset_mid();
    // reset while in WB of an ordinary write
    drive(32'h8000_2000, 5'd7, 1'b1, 32'hAAAA, 2'd1, 12'h305, 32'h1);
    step();
    idle_bus();
    rst = 1'b1;
    #1;
    n_checks++; if (rf_wen !== 1'b0 || csr_we !== 1'b0 || commit_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstwb_async got w=%0h we=%0h c=%0h r=%0h want 0/0/0/1", rf_wen, csr_we, commit_valid, in_ready); end
    step();
    rst = 1'b0;
    step();
    n_checks++; if (rf_wen !== 1'b0 || commit_valid !== 1'b0 || rf_wdata !== 32'h0) begin n_fail++; $display("FAIL rstwb_after got w=%0h c=%0h d=%h want 0/0/0", rf_wen, commit_valid, rf_wdata); end
    // reset while in CAUSE of an ecall
    mtvec_in = 32'h8000_0100;
    drive(32'h8000_3000, 5'd0, 1'b0, 32'h0, 2'd2, 12'h0, 32'h0);
    step();
    idle_bus();
    step();
    rst = 1'b1;
    #1;
    n_checks++; if (csr_we !== 1'b0 || redirect_valid !== 1'b0 || commit_valid !== 1'b0 || csr_addr !== 12'h0) begin n_fail++; $display("FAIL rstcause_async got we=%0h rv=%0h c=%0h a=%h want 0/0/0/000", csr_we, redirect_valid, commit_valid, csr_addr); end
    step();
    rst = 1'b0;
    step();
    n_checks++; if (csr_we !== 1'b0 || commit_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstcause_after got we=%0h c=%0h r=%0h want 0/0/1", csr_we, commit_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rd_zero();
    test_csrrw();
    test_ecall();
    test_mret();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
